nx_fifo_wm: RTL
===============

// Module: nx_fifo_wm
// PURPOSE
//  Parametrised single-clock synchronous FIFO; next generation of the nx_library FIFO.
//  Adds arbitrary (non-power-of-2) DEPTH and runtime almost-full/almost-empty watermarks.
//  Adds registered underflow/overflow pulses with sticky error flags.
//  Optional high-water-mark tracking. Used as the generic elastic buffer between pipeline stages.
// PARAMETERS
//  DEPTH       16  number of entries, >=2, any integer (wrap is not power-of-2 based)
//  WIDTH       32  data width in bits, >=1
//  DATA_RESET  1   1: storage array zeroed on rst; 0: storage array not reset
//  CW          $clog2(DEPTH+1)  derived count width, not user-set
// PORTS
//  clk         input   1      clock, all state on posedge
//  rst         input   1      asynchronous active-high reset
//  wen         input   1      write request
//  ren         input   1      read request (pop of current rdata)
//  clear       input   1      synchronous flush
//  wdata       input   WIDTH  write data
//  af_lvl      input   CW     almost-full threshold (entries)
//  ae_lvl      input   CW     almost-empty threshold (entries)
//  err_clr     input   1      clears sticky error flags
//  rdata       output  WIDTH  head entry; zero-latency show-ahead
//  empty       output  1      used_slots==0
//  full        output  1      used_slots==DEPTH
//  almost_full output  1      used_slots>=af_lvl
//  almost_empty output 1      used_slots<=ae_lvl
//  used_slots  output  CW     occupancy
//  free_slots  output  CW     DEPTH-used_slots
//  underflow   output  1      1-cycle pulse, registered
//  overflow    output  1      1-cycle pulse, registered
//  uf_sticky   output  1      set by underflow, held until err_clr
//  of_sticky   output  1      set by overflow, held until err_clr
// BEHAVIOUR
//  - Reset (async assert): rptr=wptr=used=0.
//    Outputs: empty=1, full=0, free_slots=DEPTH, underflow/overflow/stickies=0.
//    rdata=0. Storage zeroed iff DATA_RESET=1. Release is synchronous to clk.
//  - Write accepted iff wen && !full: mem[wptr]<=wdata, wptr advances. Read accepted iff ren && !empty.
//  - full && wen && ren: read accepted, write rejected (no pass-through), overflow pulses.
//  - Pointer wrap: DEPTH-1 -> 0 for both pointers; used counter tracks occupancy (no ptr-compare).
//  - used_slots next = used + wr_acc - rd_acc. Flags are combinational from the used register.
//    Flags are therefore valid the cycle after the accepting edge.
//  - rdata = empty ? 0 : mem[rptr]. An entry written at edge N is visible on rdata after edge N.
//  - underflow asserted the cycle after ren && empty. overflow asserted the cycle after wen && full.
//    Each is a 1-cycle pulse per offending cycle.
//  - Stickies: set on pulse. err_clr clears them; a simultaneous set wins over err_clr.
//  - clear: next edge rptr=wptr=used=0. clear has priority over wen/ren.
//    No overflow/underflow is generated in a clear cycle. Storage is untouched.
//  - Watermarks are combinational compares. af_lvl=0 -> almost_full=1 always.
//    ae_lvl>=DEPTH -> almost_empty=1 always. Thresholds may change any cycle; flags follow same cycle.
//  - rst mid-operation: all entries discarded, state as reset.
// CONFIGURATION
//  NX_FIFO_HWM_EN defined:
//    - Adds output hwm[CW] and input hwm_clr.
//    - hwm<=max(hwm, used_slots next) each cycle. hwm_clr sets hwm<=used_slots next.
//    - rst and clear zero hwm.
//  NX_FIFO_HWM_EN undefined: ports absent, no hwm logic.
// TESTING
//  DEPTH=5: 7 writes of 1..7, no reads -> full after 5th; 2 overflow pulses; of_sticky=1;
//    pop 5 -> rdata 1,2,3,4,5.
//  DEPTH=5: fill/drain 3 loops of 4 entries -> pointers wrap 4->0; data order intact; used_slots never >4.
//  Full FIFO, wen&ren same cycle -> head popped, wdata dropped, overflow=1 next cycle, used=DEPTH-1.
//  Empty, ren=1 -> underflow pulse, rdata=0. Then err_clr with no new error -> uf_sticky=0.
//  af_lvl=12, ae_lvl=3, DEPTH=16: fill to 12 -> almost_full=1 at used=12.
//    Drain to 3 -> almost_empty=1. clear with wen=1 -> used=0, no write.
//  NX_FIFO_HWM_EN: push 9, pop 6, push 2 -> hwm=9. hwm_clr -> hwm=5. rst asserted mid-burst -> hwm=0, empty=1.

Source files
------------

// File: rtl/nx_fifo_wm.sv
// nx_fifo_wm: single-clock FIFO, any DEPTH, runtime watermarks, error pulses.
// Optional high-water mark when NX_FIFO_HWM_EN is defined.
module nx_fifo_wm #(
    parameter  int DEPTH      = 16,
    parameter  int WIDTH      = 32,
    parameter  int DATA_RESET = 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    af_lvl,
    input  logic [CW-1:0]    ae_lvl,
    input  logic             err_clr,
`ifdef NX_FIFO_HWM_EN
    input  logic             hwm_clr,
    output logic [CW-1:0]    hwm,
`endif
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic             underflow,
    output logic             overflow,
    output logic             uf_sticky,
    output logic             of_sticky
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic [CW-1:0]    used;
    logic [CW-1:0]    used_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             of_ev;
    logic             uf_ev;

    // Flags come straight from the occupancy register.
    assign empty        = (used == '0);
    assign full         = (used == CW'(DEPTH));
    assign almost_full  = (used >= af_lvl);
    assign almost_empty = (used <= ae_lvl);
    assign used_slots   = used;
    assign free_slots   = CW'(DEPTH) - used;
    assign rdata        = empty ? '0 : mem[rptr];

    // Full blocks the write even when a read frees a slot in the same cycle.
    assign wr_acc = wen & ~full & ~clear;
    assign rd_acc = ren & ~empty & ~clear;
    assign of_ev  = wen & full & ~clear;
    assign uf_ev  = ren & empty & ~clear;

    // Next occupancy, shared by the counter and the high-water mark.
    always_comb begin
        used_nxt = used;
        if (clear) begin
            used_nxt = '0;
        end else begin
            used_nxt = used + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Pointers wrap at DEPTH-1, not at a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            used <= '0;
        end else begin
            used <= used_nxt;
            if (clear) begin
                rptr <= '0;
                wptr <= '0;
            end else begin
                if (wr_acc) begin
                    wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
                end
                if (rd_acc) begin
                    rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
                end
            end
        end
    end

    // Error pulses; a new error beats err_clr on the sticky copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
            uf_sticky <= 1'b0;
            of_sticky <= 1'b0;
        end else begin
            underflow <= uf_ev;
            overflow  <= of_ev;
            uf_sticky <= uf_ev | (uf_sticky & ~err_clr);
            of_sticky <= of_ev | (of_sticky & ~err_clr);
        end
    end

    generate
        if (DATA_RESET != 0) begin : g_mem_rst
            // Storage cleared by reset, written on accepted pushes.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (wr_acc) begin
                    mem[wptr] <= wdata;
                end
            end
        end else begin : g_mem_nrst
            // Storage without reset, written on accepted pushes.
            always_ff @(posedge clk) begin
                if (wr_acc) begin
                    mem[wptr] <= wdata;
                end
            end
        end
    endgenerate

`ifdef NX_FIFO_HWM_EN
    // Peak occupancy; hwm_clr restarts tracking from the next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm <= '0;
        end else if (clear) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= used_nxt;
        end else if (used_nxt > hwm) begin
            hwm <= used_nxt;
        end
    end
`endif

endmodule
